demultiplex_buffered: RTL and testbench

DEMULTIPLEX_BUFFERED -- requirements
Module: demultiplex_buffered

---
 rtl/demultiplex_buffered_pkg.sv | 20 ++
 rtl/demultiplex_slot.sv | 33 +++
 rtl/demultiplex_buffered.sv | 77 +++++++
 tb/tb_demultiplex_buffered.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/demultiplex_buffered_pkg.sv
// rtl/demultiplex_buffered_pkg.sv - word classification shared by the demultiplexer top
package demultiplex_buffered_pkg;

    typedef enum logic [1:0] {
        WORD_UNICAST = 2'd0,
        WORD_BCAST   = 2'd1,
        WORD_DROP    = 2'd2
    } word_kind_e;

    // Broadcast takes precedence over select validity; the select field is ignored then.
    function automatic word_kind_e classify(input logic bcast, input logic sel_ok);
        if (bcast)
            return WORD_BCAST;
        else if (sel_ok)
            return WORD_UNICAST;
        else
            return WORD_DROP;
    endfunction

endpackage

// File: rtl/demultiplex_slot.sv
// rtl/demultiplex_slot.sv - one-entry holding slot per master channel
module demultiplex_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    input  logic         i_drain,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    // A load in the same cycle as a drain keeps the slot full for full throughput.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (r_valid && i_drain) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/demultiplex_buffered.sv
// rtl/demultiplex_buffered.sv - one-to-N demultiplexer with a registered slot per channel
module demultiplex_buffered
    import demultiplex_buffered_pkg::*;
#(
    parameter  int W     = 8,
    parameter  int N     = 2,
    parameter  int BCAST = 0,
    localparam int S     = $clog2(N),
    localparam int SW    = 1 + S + W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           s_stb,
    input  logic [SW-1:0]  s_dat,
    output logic           s_rdy,
    output logic [N-1:0]   m_stb,
    output logic [N*W-1:0] m_dat,
    input  logic [N-1:0]   m_rdy,
    output logic           err
);

    logic [S-1:0] w_sel;
    logic         w_bc;
    logic         w_sel_ok;
    word_kind_e   w_kind;
    logic [N-1:0] w_valid;
    logic [N-1:0] w_free;
    logic [N-1:0] w_load;
    logic         r_err;

    assign w_sel    = s_dat[W+:S];
    assign w_bc     = (BCAST != 0) && s_dat[W+S];
    assign w_sel_ok = 32'(w_sel) < 32'(N);
    assign w_kind   = classify(w_bc, w_sel_ok);
    assign w_free   = ~w_valid | m_rdy;

    // Broadcast waits for every slot so the channels never see a partial copy.
    always_comb begin
        s_rdy  = 1'b0;
        w_load = '0;
        if (rst_n && s_stb) begin
            case (w_kind)
                WORD_BCAST: s_rdy = &w_free;
                WORD_DROP:  s_rdy = 1'b1;
                default:    s_rdy = w_free[w_sel];
            endcase
        end
        for (int i = 0; i < N; i++) begin
            if (s_rdy && (w_kind == WORD_BCAST ||
                          (w_kind == WORD_UNICAST && w_sel == S'(i))))
                w_load[i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_err <= 1'b0;
        else
            r_err <= s_rdy && (w_kind == WORD_DROP);
    end

    for (genvar g = 0; g < N; g++) begin : g_slot
        demultiplex_slot #(.W(W)) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_load  (w_load[g]),
            .i_data  (s_dat[W-1:0]),
            .i_drain (m_rdy[g]),
            .o_valid (w_valid[g]),
            .o_data  (m_dat[g*W+:W])
        );
    end

    assign m_stb = w_valid;
    assign err   = r_err;

endmodule

// File: tb/tb_demultiplex_buffered.sv
// tb/tb_demultiplex_buffered.sv - randomized and directed bench against a behavioural slot model
module tb_demultiplex_buffered;

    localparam int W  = 8;
    localparam int N  = 3;
    localparam int SW = 11;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_stb;
    logic [SW-1:0] s_dat;
    logic          s_rdy;
    logic [N-1:0]  m_stb;
    logic [N*W-1:0] m_dat;
    logic [N-1:0]  m_rdy;
    logic          err;

    int checks = 0;
    int errors = 0;

    logic [N-1:0] mv;
    logic [W-1:0] md [N];
    logic         merr;
    logic         exp_rdy, obs_rdy;

    demultiplex_buffered #(.W(W), .N(N), .BCAST(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s_stb (s_stb),
        .s_dat (s_dat),
        .s_rdy (s_rdy),
        .m_stb (m_stb),
        .m_dat (m_dat),
        .m_rdy (m_rdy),
        .err   (err)
    );

    always #5 clk = ~clk;

    function automatic logic [SW-1:0] word(input logic bc, input int sel, input logic [W-1:0] pay);
        logic [1:0] s2;
        s2 = 2'(sel);
        return {bc, s2, pay};
    endfunction

    function automatic logic [N*W-1:0] exp_dat();
        return {md[2], md[1], md[0]};
    endfunction

    // Acceptance decided from the rules: a broadcast needs every channel free,
    // an out-of-range select is always swallowed, otherwise the target must be free.
    function automatic logic model_rdy();
        int  sel;
        logic all_free;
        sel = int'(s_dat[9:8]);
        all_free = 1'b1;
        for (int i = 0; i < N; i++)
            if (mv[i] && !m_rdy[i]) all_free = 1'b0;
        if (!rst_n || !s_stb) return 1'b0;
        if (s_dat[10]) return all_free;
        if (sel >= N) return 1'b1;
        return !mv[sel] || m_rdy[sel];
    endfunction

    task automatic cycle();
        int sel;
        @(negedge clk);
        exp_rdy = model_rdy();
        obs_rdy = s_rdy;
        @(posedge clk);
        sel = int'(s_dat[9:8]);
        if (!rst_n) begin
            mv = '0;
            for (int i = 0; i < N; i++) md[i] = '0;
            merr = 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (exp_rdy && (s_dat[10] || sel == i)) begin
                    mv[i] = 1'b1;
                    md[i] = s_dat[7:0];
                end else if (mv[i] && m_rdy[i]) begin
                    mv[i] = 1'b0;
                end
            end
            merr = exp_rdy && !s_dat[10] && sel >= N;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; s_stb = 1'b1; s_dat = word(1'b0, 1, 8'h99); m_rdy = 3'b111;
        mv = '0; merr = 1'b0;
        for (int i = 0; i < N; i++) md[i] = '0;
        cycle(); cycle();
        checks++; if (m_stb !== 3'b000) begin errors++; $display("FAIL reset_m_stb got %b want 000", m_stb); end
        checks++; if (m_dat !== '0) begin errors++; $display("FAIL reset_m_dat got %h want 0", m_dat); end
        checks++; if (obs_rdy !== 1'b0) begin errors++; $display("FAIL reset_s_rdy got %b want 0", obs_rdy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
        rst_n = 1'b1; s_stb = 1'b0;
        cycle();
    endtask

    task automatic test_unicast();
        m_rdy = 3'b111; s_stb = 1'b1; s_dat = word(1'b0, 1, 8'hA5);
        cycle();
        checks++; if (obs_rdy !== 1'b1) begin errors++; $display("FAIL uni_rdy0 got %b want 1", obs_rdy); end
        checks++; if (m_stb !== 3'b010 || m_dat[15:8] !== 8'hA5) begin errors++; $display("FAIL uni_word0 got %b/%h want 010/a5", m_stb, m_dat[15:8]); end
        s_dat = word(1'b0, 1, 8'h5A);
        cycle();
        checks++; if (obs_rdy !== 1'b1) begin errors++; $display("FAIL uni_rdy1 got %b want 1", obs_rdy); end
        checks++; if (m_stb !== 3'b010 || m_dat[15:8] !== 8'h5A) begin errors++; $display("FAIL uni_word1 got %b/%h want 010/5a", m_stb, m_dat[15:8]); end
        s_stb = 1'b0;
        cycle();
        checks++; if (m_stb !== 3'b000 || m_dat[15:8] !== 8'h5A) begin errors++; $display("FAIL uni_drain got %b/%h want 000/5a", m_stb, m_dat[15:8]); end
    endtask

    task automatic test_backpressure();
        m_rdy = 3'b110; s_stb = 1'b1; s_dat = word(1'b0, 0, 8'h11);
        cycle();
        s_dat = word(1'b0, 0, 8'h22);
        cycle();
        checks++; if (obs_rdy !== 1'b0) begin errors++; $display("FAIL bp_blocked_rdy got %b want 0", obs_rdy); end
        s_dat = word(1'b0, 2, 8'h33);
        cycle();
        checks++; if (obs_rdy !== 1'b1) begin errors++; $display("FAIL bp_other_rdy got %b want 1", obs_rdy); end
        checks++; if (m_stb !== 3'b101 || m_dat[23:16] !== 8'h33 || m_dat[7:0] !== 8'h11) begin errors++; $display("FAIL bp_isolation got %b/%h want 101/33xx11", m_stb, m_dat); end
        s_stb = 1'b0; m_rdy = 3'b111;
        cycle();
        checks++; if (m_stb !== 3'b000 || m_dat[7:0] !== 8'h11) begin errors++; $display("FAIL bp_release got %b/%h want 000/11", m_stb, m_dat[7:0]); end
    endtask

    task automatic test_broadcast();
        m_rdy = 3'b101; s_stb = 1'b1; s_dat = word(1'b0, 1, 8'h77);
        cycle();
        s_dat = word(1'b1, 0, 8'h3C);
        cycle();
        checks++; if (obs_rdy !== 1'b0) begin errors++; $display("FAIL bc_blocked_rdy got %b want 0", obs_rdy); end
        checks++; if (m_stb !== 3'b010 || m_dat[15:8] !== 8'h77) begin errors++; $display("FAIL bc_no_partial got %b/%h want 010/77", m_stb, m_dat[15:8]); end
        m_rdy = 3'b111;
        cycle();
        checks++; if (obs_rdy !== 1'b1) begin errors++; $display("FAIL bc_rdy got %b want 1", obs_rdy); end
        checks++; if (m_stb !== 3'b111 || m_dat !== 24'h3C3C3C) begin errors++; $display("FAIL bc_all got %b/%h want 111/3c3c3c", m_stb, m_dat); end
        s_stb = 1'b0;
        cycle();
    endtask

    task automatic test_invalid_select();
        m_rdy = 3'b000; s_stb = 1'b1; s_dat = word(1'b0, 0, 8'h44);
        cycle();
        s_dat = word(1'b0, 3, 8'hFF);
        cycle();
        checks++; if (obs_rdy !== 1'b1) begin errors++; $display("FAIL inv_rdy got %b want 1", obs_rdy); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL inv_err got %b want 1", err); end
        checks++; if (m_stb !== 3'b001 || m_dat[7:0] !== 8'h44) begin errors++; $display("FAIL inv_slots got %b/%h want 001/44", m_stb, m_dat[7:0]); end
        s_stb = 1'b0;
        cycle();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL inv_err_pulse got %b want 0", err); end
        m_rdy = 3'b111;
        cycle();
    endtask

    task automatic test_reset_mid();
        m_rdy = 3'b000; s_stb = 1'b1; s_dat = word(1'b0, 0, 8'hD0);
        cycle();
        s_dat = word(1'b0, 2, 8'hD2);
        cycle();
        checks++; if (m_stb !== 3'b101) begin errors++; $display("FAIL rm_loaded got %b want 101", m_stb); end
        s_stb = 1'b0; rst_n = 1'b0;
        cycle();
        checks++; if (m_stb !== 3'b000 || m_dat !== '0) begin errors++; $display("FAIL rm_cleared got %b/%h want 000/0", m_stb, m_dat); end
        rst_n = 1'b1; m_rdy = 3'b111; s_stb = 1'b1; s_dat = word(1'b0, 1, 8'hE1);
        cycle();
        checks++; if (obs_rdy !== 1'b1) begin errors++; $display("FAIL rm_first_rdy got %b want 1", obs_rdy); end
        checks++; if (m_stb !== 3'b010 || m_dat !== 24'h00E100) begin errors++; $display("FAIL rm_no_stale got %b/%h want 010/00e100", m_stb, m_dat); end
        s_stb = 1'b0;
        cycle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            s_stb = ($urandom_range(0, 3) != 0);
            s_dat = word($urandom_range(0, 3) == 0, $urandom_range(0, 3), 8'($urandom));
            m_rdy = 3'($urandom);
            cycle();
            checks++; if (obs_rdy !== exp_rdy) begin errors++; $display("FAIL rnd_rdy cyc %0d got %b want %b", n, obs_rdy, exp_rdy); end
            checks++; if (m_stb !== mv) begin errors++; $display("FAIL rnd_stb cyc %0d got %b want %b", n, m_stb, mv); end
            checks++; if (m_dat !== exp_dat()) begin errors++; $display("FAIL rnd_dat cyc %0d got %h want %h", n, m_dat, exp_dat()); end
            checks++; if (err !== merr) begin errors++; $display("FAIL rnd_err cyc %0d got %b want %b", n, err, merr); end
        end
    endtask

    initial begin
        test_reset();
        test_unicast();
        test_backpressure();
        test_broadcast();
        test_invalid_select();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
